hawk_axi_wr_mstr: RTL and testbench

Downstream write stage of the Hawk page-write manager: accepts its single-beat cache-line write requests (`wr_reqpkt`) and returns readiness (`wr_rdypkt`). Converts each request into a single-beat AXI4 INCR burst on the AW/W channels, tracks outstanding writes until their B response, and reports idle/error status to the Hawk control unit. All upstream writes funnel through this block on their way to the memory-side AXI fabric.

---
 rtl/hacd_pkg.sv | 29 ++
 rtl/hawk_axi_slot.sv | 43 ++++
 rtl/hawk_axi_wr_mstr.sv | 134 +++++++++++++
 tb/tb_hawk_axi_wr_mstr.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hacd_pkg.sv
// Shared Hawk types: upstream write request/ready packets and the AXI
// encodings used by the write master.
package hacd_pkg;

  typedef struct packed {
    logic [63:0]  addr;
    logic [511:0] data;
    logic [63:0]  strb;
    logic         awvalid;
    logic         wvalid;
  } axi_wr_reqpkt_t;

  typedef struct packed {
    logic awready;
    logic wready;
  } axi_wr_rdypkt_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_64B   = 3'b110;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam int unsigned LINE_ADDR_W = 58;

  // Cache-line number of a byte address (64-byte lines).
  function automatic logic [LINE_ADDR_W-1:0] line_of(input logic [63:0] addr);
    return addr[63:6];
  endfunction

endpackage

// File: rtl/hawk_axi_slot.sv
// One-entry holding register: loads when pushed while empty, drains on the
// downstream valid/ready handshake. No bypass, so a drain and a load never
// happen in the same cycle.
module hawk_axi_slot #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (full_q) begin
      if (ready_i) full_d = 1'b0;
    end else if (push_i) begin
      full_d = 1'b1;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign valid_o = full_q;
  assign data_o  = data_q;

endmodule

// File: rtl/hawk_axi_wr_mstr.sv
// Hawk downstream write stage: turns single-line upstream writes into
// single-beat AXI4 INCR writes and tracks them until their B response.
module hawk_axi_wr_mstr
  import hacd_pkg::*;
#(
  parameter int unsigned AXI_ID_WIDTH    = 4,
  parameter int unsigned AXI_ID          = 0,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  axi_wr_reqpkt_t          wr_reqpkt,
  output axi_wr_rdypkt_t          wr_rdypkt,
  output logic [AXI_ID_WIDTH-1:0] m_axi_awid,
  output logic [63:0]             m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [511:0]            m_axi_wdata,
  output logic [63:0]             m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [AXI_ID_WIDTH-1:0] m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic                    wr_idle,
  output logic                    wr_err,
  output logic [15:0]             wr_err_cnt
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high. Upstream valids are single-cycle pulses and are only legal
  // while the matching ready is high; fabric valids hold until accepted.

  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  logic                   aw_ready, w_ready;
  logic                   aw_push, w_push, b_hs;
  logic [LINE_ADDR_W-1:0] aw_line;
  logic [3:0]             out_cnt_q, out_cnt_d;
  logic [3:0]             w_owed_q, w_owed_d;
  logic                   err_q, err_d;
  logic [15:0]            err_cnt_q, err_cnt_d;
  logic                   b_dec;
  logic                   unused_ok;

  assign aw_ready  = ~m_axi_awvalid & (out_cnt_q < MAX_OUT);
  assign w_ready   = ~m_axi_wvalid & (w_owed_q != 4'd0);
  assign wr_rdypkt = '{awready: aw_ready, wready: w_ready};

  assign aw_push = wr_reqpkt.awvalid & aw_ready;
  assign w_push  = wr_reqpkt.wvalid & w_ready;
  assign b_hs    = m_axi_bvalid & m_axi_bready;
  // A B with nothing outstanding is flagged but must not underflow the count.
  assign b_dec   = b_hs & (out_cnt_q != 4'd0);

  hawk_axi_slot #(.WIDTH(LINE_ADDR_W)) u_aw_slot (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (aw_push),
    .data_i  (line_of(wr_reqpkt.addr)),
    .valid_o (m_axi_awvalid),
    .ready_i (m_axi_awready),
    .data_o  (aw_line)
  );

  hawk_axi_slot #(.WIDTH(576)) u_w_slot (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .data_i  ({wr_reqpkt.data, wr_reqpkt.strb}),
    .valid_o (m_axi_wvalid),
    .ready_i (m_axi_wready),
    .data_o  ({m_axi_wdata, m_axi_wstrb})
  );

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (aw_push && !b_dec)      out_cnt_d = out_cnt_q + 4'd1;
    else if (!aw_push && b_dec) out_cnt_d = out_cnt_q - 4'd1;

    w_owed_d = w_owed_q;
    if (aw_push && !w_push)      w_owed_d = w_owed_q + 4'd1;
    else if (!aw_push && w_push) w_owed_d = w_owed_q - 4'd1;

    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (b_hs) begin
      if (m_axi_bresp != AXI_RESP_OKAY || out_cnt_q == 4'd0) err_d = 1'b1;
      if (m_axi_bresp != AXI_RESP_OKAY && err_cnt_q != 16'hFFFF)
        err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_cnt_q <= 4'd0;
      w_owed_q  <= 4'd0;
      err_q     <= 1'b0;
      err_cnt_q <= 16'd0;
    end else begin
      out_cnt_q <= out_cnt_d;
      w_owed_q  <= w_owed_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign m_axi_awid    = AXI_ID_WIDTH'(AXI_ID);
  assign m_axi_awaddr  = {aw_line, 6'b0};
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = AXI_SIZE_64B;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_wlast   = 1'b1;
  assign m_axi_bready  = 1'b1;

  assign wr_idle    = ~m_axi_awvalid & ~m_axi_wvalid & (out_cnt_q == 4'd0) & (w_owed_q == 4'd0);
  assign wr_err     = err_q;
  assign wr_err_cnt = err_cnt_q;

  // bid is deliberately ignored; low address bits are dropped by line alignment.
  assign unused_ok = ^{m_axi_bid, wr_reqpkt.addr[5:0]};

  // Upstream must not pulse while the matching ready is low.
  a_aw_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
                               wr_reqpkt.awvalid |-> aw_ready);
  a_w_legal:  assert property (@(posedge clk_i) disable iff (!rst_ni)
                               wr_reqpkt.wvalid |-> w_ready);

endmodule

// File: tb/tb_hawk_axi_wr_mstr.sv
// Bench for hawk_axi_wr_mstr: directed scenarios plus randomized traffic,
// with a negedge monitor checking against a transaction-level model.
module tb_hawk_axi_wr_mstr;
  import hacd_pkg::*;

  localparam int MAXO = 4;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  axi_wr_reqpkt_t wr_reqpkt;
  axi_wr_rdypkt_t wr_rdypkt;
  logic [3:0]     m_axi_awid;
  logic [63:0]    m_axi_awaddr;
  logic [7:0]     m_axi_awlen;
  logic [2:0]     m_axi_awsize;
  logic [1:0]     m_axi_awburst;
  logic           m_axi_awvalid, m_axi_awready;
  logic [511:0]   m_axi_wdata;
  logic [63:0]    m_axi_wstrb;
  logic           m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [3:0]     m_axi_bid;
  logic [1:0]     m_axi_bresp;
  logic           m_axi_bvalid, m_axi_bready;
  logic           wr_idle, wr_err;
  logic [15:0]    wr_err_cnt;

  hawk_axi_wr_mstr #(.AXI_ID_WIDTH(4), .AXI_ID(0), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .wr_reqpkt(wr_reqpkt), .wr_rdypkt(wr_rdypkt),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .wr_idle(wr_idle), .wr_err(wr_err), .wr_err_cnt(wr_err_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [63:0]  exp_q[$];
  logic [575:0] exp_w_q[$];

  // Reference model: what the block should hold, in transaction terms.
  bit m_aw_pending, m_w_pending, m_err;
  int m_out, m_owed, m_err_cnt;
  int m_aw_hs, m_w_hs;
  int b_issued;

  task automatic check(input string name, input logic [575:0] act, input logic [575:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk_i) begin
    bit exp_awr, exp_wr, acc_aw, acc_w;
    logic [575:0] w_exp;
    if (!rst_ni) begin
      m_aw_pending = 0; m_w_pending = 0; m_err = 0;
      m_out = 0; m_owed = 0; m_err_cnt = 0; m_aw_hs = 0; m_w_hs = 0;
      exp_q.delete();
      exp_w_q.delete();
      check("rst_awvalid", m_axi_awvalid, 0);
      check("rst_wvalid", m_axi_wvalid, 0);
      check("rst_awaddr", m_axi_awaddr, 0);
      check("rst_wdata", {m_axi_wdata, m_axi_wstrb}, 0);
      check("rst_err", {wr_err, wr_err_cnt}, 0);
      check("rst_bready", m_axi_bready, 1);
    end else begin
      exp_awr = !m_aw_pending && (m_out < MAXO);
      exp_wr  = !m_w_pending && (m_owed != 0);
      check("awready", wr_rdypkt.awready, exp_awr);
      check("wready", wr_rdypkt.wready, exp_wr);
      check("awvalid", m_axi_awvalid, m_aw_pending);
      check("wvalid", m_axi_wvalid, m_w_pending);
      check("idle", wr_idle, !m_aw_pending && !m_w_pending && m_out == 0 && m_owed == 0);
      check("err", wr_err, m_err);
      check("err_cnt", wr_err_cnt, 16'(m_err_cnt));
      check("bready", m_axi_bready, 1);

      if (m_axi_awvalid && m_axi_awready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL aw_unexpected: got addr %0h expected no AW", m_axi_awaddr);
        end else begin
          check("awaddr", m_axi_awaddr, exp_q.pop_front());
        end
        check("aw_fixed", {m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst},
              {4'd0, 8'd0, 3'd6, 2'b01});
        m_aw_hs++;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        if (exp_w_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL w_unexpected: got strb %0h expected no W", m_axi_wstrb);
        end else begin
          w_exp = exp_w_q.pop_front();
          check("wpayload", {m_axi_wdata, m_axi_wstrb}, w_exp);
        end
        check("wlast", m_axi_wlast, 1);
        m_w_hs++;
      end

      // advance the model to the state after the coming rising edge
      acc_aw = wr_reqpkt.awvalid && exp_awr;
      acc_w  = wr_reqpkt.wvalid && exp_wr;
      if (m_aw_pending && m_axi_awready) m_aw_pending = 0;
      else if (acc_aw)                   m_aw_pending = 1;
      if (m_w_pending && m_axi_wready) m_w_pending = 0;
      else if (acc_w)                  m_w_pending = 1;
      m_owed = m_owed + int'(acc_aw) - int'(acc_w);
      if (acc_aw) m_out++;
      if (m_axi_bvalid) begin
        if (m_out - int'(acc_aw) == 0) m_err = 1;
        else m_out--;
        if (m_axi_bresp != 2'b00) begin
          m_err = 1;
          if (m_err_cnt < 16'hFFFF) m_err_cnt++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
    wr_reqpkt.awvalid = 1'b0;
    wr_reqpkt.wvalid  = 1'b0;
    m_axi_bvalid      = 1'b0;
    m_axi_bresp       = 2'b00;
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic send_aw(input logic [63:0] a);
    wr_reqpkt.addr    = a;
    wr_reqpkt.awvalid = 1'b1;
    exp_q.push_back({a[63:6], 6'b0});
  endtask

  task automatic send_w(input logic [511:0] d, input logic [63:0] s);
    wr_reqpkt.data   = d;
    wr_reqpkt.strb   = s;
    wr_reqpkt.wvalid = 1'b1;
    exp_w_q.push_back({d, s});
  endtask

  task automatic send_b(input logic [1:0] resp);
    m_axi_bvalid = 1'b1;
    m_axi_bresp  = resp;
    m_axi_bid    = 4'($urandom_range(0, 15));
    b_issued++;
  endtask

  task automatic wait_rdy(input bit is_w, input string name);
    int n = 0;
    while (((is_w ? wr_rdypkt.wready : wr_rdypkt.awready) !== 1'b1) && n < 50) begin
      tick(); n++;
    end
    checks++;
    if (n >= 50) begin errors++; $display("FAIL %s: ready never rose, got 0 expected 1", name); end
  endtask

  task automatic wait_hs(input int aw_t, input int w_t, input string name);
    int n = 0;
    while ((m_aw_hs < aw_t || m_w_hs < w_t) && n < 100) begin tick(); n++; end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL %s: handshakes aw=%0d w=%0d expected aw=%0d w=%0d", name, m_aw_hs, m_w_hs, aw_t, w_t);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] a;
    int base_aw, base_w, n, lim;
    wr_reqpkt = '0;
    m_axi_awready = 0; m_axi_wready = 0;
    m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_bid = 0;
    b_issued = 0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // reset / idle
    check("idle_awready", wr_rdypkt.awready, 1);
    check("idle_wready", wr_rdypkt.wready, 0);
    check("idle_idle", wr_idle, 1);
    check("idle_valids", {m_axi_awvalid, m_axi_wvalid}, 0);

    // single write
    m_axi_awready = 1; m_axi_wready = 1;
    send_aw(64'h8000_0040);
    tick();
    check("sw_awvalid", m_axi_awvalid, 1);
    check("sw_awaddr", m_axi_awaddr, 64'h8000_0040);
    check("sw_awready_low", wr_rdypkt.awready, 0);
    check("sw_wready", wr_rdypkt.wready, 1);
    send_w(rand_line(), 64'hFFFF);
    tick();
    check("sw_wvalid", {m_axi_wvalid, m_axi_wlast}, 2'b11);
    wait_hs(1, 1, "sw_hs");
    send_b(2'b00);
    tick();
    check("sw_idle", {wr_idle, wr_err}, 2'b10);

    // fabric AW stalled: AW holds, W completes on its own
    m_axi_awready = 0;
    base_aw = m_aw_hs; base_w = m_w_hs;
    a = {$urandom, $urandom};
    send_aw(a);
    tick();
    send_w(rand_line(), {$urandom, $urandom});
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_awvalid", m_axi_awvalid, 1);
      check("stall_awaddr", m_axi_awaddr, {a[63:6], 6'b0});
      check("stall_up_awready", wr_rdypkt.awready, 0);
    end
    check("stall_w_done", m_w_hs - base_w, 1);
    m_axi_awready = 1;
    wait_hs(base_aw + 1, base_w + 1, "stall_hs");
    send_b(2'b00);
    tick();

    // fill to MAX_OUTSTANDING with B withheld
    base_aw = m_aw_hs; base_w = m_w_hs;
    for (int k = 0; k < MAXO; k++) begin
      wait_rdy(0, "fill_awready");
      send_aw({$urandom, $urandom});
      tick();
      wait_rdy(1, "fill_wready");
      send_w(rand_line(), {$urandom, $urandom});
      tick();
    end
    wait_hs(base_aw + MAXO, base_w + MAXO, "fill_hs");
    repeat (3) begin
      tick();
      check("fill_awready_low", wr_rdypkt.awready, 0);
    end
    send_b(2'b00);
    tick();
    check("fill_awready_back", wr_rdypkt.awready, 1);

    // error response, drain, then an unexpected B
    send_b(2'b10);
    tick();
    check("slverr_err", {wr_err, wr_err_cnt}, {1'b1, 16'd1});
    send_b(2'b00); tick();
    send_b(2'b00); tick();
    check("drained_idle", wr_idle, 1);
    m_axi_bvalid = 1; m_axi_bresp = 2'b00;
    tick();
    check("stray_b_err", {wr_err, wr_err_cnt}, {1'b1, 16'd1});
    check("stray_b_idle", {wr_idle, wr_rdypkt.awready}, 2'b11);

    // reset with both fabric valids pending
    m_axi_awready = 0; m_axi_wready = 0;
    send_aw({$urandom, $urandom});
    tick();
    send_w(rand_line(), {$urandom, $urandom});
    tick();
    check("pre_rst_valids", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
    rst_ni = 1'b0;
    b_issued = 0;
    #1;
    check("mid_rst_valids", {m_axi_awvalid, m_axi_wvalid}, 2'b00);
    check("mid_rst_err", {wr_err, wr_err_cnt}, 0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    tick();
    check("post_rst_idle", {wr_idle, wr_rdypkt.awready, wr_rdypkt.wready}, 3'b110);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      m_axi_awready = ($urandom_range(0, 3) != 0);
      m_axi_wready  = ($urandom_range(0, 3) != 0);
      if (wr_rdypkt.awready && $urandom_range(0, 1) == 1) send_aw({$urandom, $urandom});
      if (wr_rdypkt.wready && $urandom_range(0, 1) == 1) send_w(rand_line(), {$urandom, $urandom});
      lim = (m_aw_hs < m_w_hs) ? m_aw_hs : m_w_hs;
      if (b_issued < lim && $urandom_range(0, 2) == 0)
        send_b(($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
      tick();
    end

    // drain: finish every owed W and return every B
    m_axi_awready = 1; m_axi_wready = 1;
    n = 0;
    while (n < 300 && !(wr_idle === 1'b1)) begin
      if (wr_rdypkt.wready) send_w(rand_line(), {$urandom, $urandom});
      lim = (m_aw_hs < m_w_hs) ? m_aw_hs : m_w_hs;
      if (b_issued < lim) send_b(2'b00);
      tick();
      n++;
    end
    check("final_idle", wr_idle, 1);
    check("final_queues", exp_q.size() + exp_w_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
